// File: rtl/vitis_net_p4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vitis_net_p4_pkg
// Description : Shared constants, the output-register beat type and the
//               Ethernet/IPv4 first-beat classifier used by vitis_net_p4.
// Revision    : 1.0 - initial release
// ============================================================================
package vitis_net_p4_pkg;

    localparam int DATA_BYTES = 64;
    localparam int DATA_W     = DATA_BYTES * 8;
    localparam int META_W     = 9;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [3:0]  IPV4_VERSION   = 4'd4;

    // Byte offsets within the first beat; byte 0 is first on the wire.
    localparam int ETH_TYPE_OFS = 12;
    localparam int IP_VER_OFS   = 14;
    localparam int IP_PROTO_OFS = 23;

    // Contents of the egress register: one forwarded beat plus its tags.
    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [DATA_BYTES-1:0] keep;
        logic                  last;
        logic                  first;
        logic [META_W-1:0]     meta;
    } beat_t;

    function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] d,
                                            input int unsigned       k);
        return d[8*k +: 8];
    endfunction

    // IPv4 packets are tagged with the protocol number and bit 8 set;
    // everything else carries the captured input metadata through.
    function automatic logic [META_W-1:0] classify(input logic [DATA_W-1:0] d,
                                                   input logic [META_W-1:0] in_meta);
        logic [15:0] ethertype;
        logic [7:0]  ver_byte;
        logic [7:0]  proto;
        ethertype = {get_byte(d, ETH_TYPE_OFS), get_byte(d, ETH_TYPE_OFS + 1)};
        ver_byte  = get_byte(d, IP_VER_OFS);
        proto     = get_byte(d, IP_PROTO_OFS);
        if ((ethertype == ETHERTYPE_IPV4) && (ver_byte[7:4] == IPV4_VERSION)) begin
            return {1'b1, proto};
        end
        return in_meta;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vitis_net_p4_if.sv
`default_nettype none
// ============================================================================
// Module      : vitis_net_p4_if
// Description : AXI-Stream bundle (tdata/tkeep/tvalid/tready/tlast) with
//               master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface vitis_net_p4_if #(
    parameter int TDATA_NUM_BYTES = 64
);
    logic [TDATA_NUM_BYTES*8-1:0] tdata;
    logic [TDATA_NUM_BYTES-1:0]   tkeep;
    logic                         tvalid;
    logic                         tready;
    logic                         tlast;

    modport master (output tdata, output tkeep, output tvalid, output tlast,
                    input  tready);
    modport slave  (input  tdata, input  tkeep, input  tvalid, input  tlast,
                    output tready);
endinterface
`default_nettype wire

// File: rtl/vitis_net_p4_axis_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : axis_skid_buffer
// Description : Two-entry valid/ready register slice. The output entry is the
//               registered egress stage; the skid entry absorbs the one beat
//               that can arrive in the cycle a stall begins. s_ready depends
//               only on local state, breaking the ready path. Used by
//               vitis_net_p4 when VITIS_NET_P4_SKID_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             s_valid,
    output logic                  s_ready,
    input  wire logic [WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  wire logic             m_ready,
    output logic [WIDTH-1:0]      m_data
);

    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             main_valid;
    logic             skid_valid;
    logic             s_fire;
    logic             out_free;

    assign s_ready  = rst_n & ~skid_valid;
    assign s_fire   = s_valid & s_ready;
    assign out_free = ~main_valid | m_ready;
    assign m_valid  = main_valid;
    assign m_data   = main_data;

    // Refill the output entry from the skid entry first, else from the input;
    // park an incoming beat in the skid entry while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data  <= '0;
            skid_data  <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (s_fire) begin
                main_data  <= s_data;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (s_fire) begin
            skid_data  <= s_data;
            skid_valid <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vitis_net_p4.sv
`default_nettype none
// ============================================================================
// Module      : vitis_net_p4
// Description : Single-stage AXI-Stream packet classifier. Forwards every beat
//               unchanged through one register stage and tags each packet with
//               a 9-bit metadata word derived from its first beat
//               (IPv4 -> {1, protocol}, otherwise the input metadata).
//               Build option VITIS_NET_P4_SKID_EN inserts a two-entry skid
//               buffer so s_axis_tready has no path from m_axis_tready.
// Revision    : 1.0 - initial release
// ============================================================================
module vitis_net_p4
    import vitis_net_p4_pkg::*;
#(
    parameter int TDATA_NUM_BYTES      = 64,
    parameter int USER_META_DATA_WIDTH = 9
) (
    input  wire logic                            s_axis_aclk,
    input  wire logic                            s_axis_aresetn,
    input  wire logic [USER_META_DATA_WIDTH-1:0] user_metadata_in,
    input  wire logic                            user_metadata_in_valid,
    output logic [USER_META_DATA_WIDTH-1:0]      user_metadata_out,
    output logic                                 user_metadata_out_valid,
    vitis_net_p4_if.slave                        s_axis,
    vitis_net_p4_if.master                       m_axis
);

    localparam int STREAM_W = TDATA_NUM_BYTES * 8;

    logic [STREAM_W-1:0] in_data;
    logic                accept;
    logic                first_beat;
    logic [META_W-1:0]   in_meta;
    logic [META_W-1:0]   meta_hold;
    logic [META_W-1:0]   beat_meta;
    beat_t               in_beat;
    beat_t               out_beat;
    logic                out_valid;

    assign in_data = s_axis.tdata;
    assign accept  = s_axis.tvalid & s_axis.tready;
    assign in_meta = user_metadata_in_valid ? user_metadata_in[META_W-1:0] : '0;

    // Non-first beats carry the packet's metadata so the output keeps it.
    assign beat_meta = first_beat ? classify(in_data, in_meta) : meta_hold;

    assign in_beat.data  = in_data;
    assign in_beat.keep  = s_axis.tkeep;
    assign in_beat.last  = s_axis.tlast;
    assign in_beat.first = first_beat;
    assign in_beat.meta  = beat_meta;

    // Track packet boundaries and remember the current packet's metadata.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            first_beat <= 1'b1;
            meta_hold  <= '0;
        end else if (accept) begin
            first_beat <= s_axis.tlast;
            meta_hold  <= beat_meta;
        end
    end

`ifdef VITIS_NET_P4_SKID_EN
    logic [$bits(beat_t)-1:0] out_bits;

    axis_skid_buffer #(
        .WIDTH($bits(beat_t))
    ) u_skid (
        .clk     (s_axis_aclk),
        .rst_n   (s_axis_aresetn),
        .s_valid (s_axis.tvalid),
        .s_ready (s_axis.tready),
        .s_data  (in_beat),
        .m_valid (out_valid),
        .m_ready (m_axis.tready),
        .m_data  (out_bits)
    );

    assign out_beat = beat_t'(out_bits);
`else
    assign s_axis.tready = s_axis_aresetn & (~out_valid | m_axis.tready);

    // Single egress register: load on accept, empty once drained.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            out_beat  <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_beat  <= in_beat;
            out_valid <= 1'b1;
        end else if (m_axis.tready) begin
            out_valid <= 1'b0;
        end
    end
`endif

    assign m_axis.tvalid           = out_valid;
    assign m_axis.tdata            = out_beat.data;
    assign m_axis.tkeep            = out_beat.keep;
    assign m_axis.tlast            = out_beat.last;
    assign user_metadata_out       = USER_META_DATA_WIDTH'(out_beat.meta);
    assign user_metadata_out_valid = out_valid & out_beat.first;

endmodule
`default_nettype wire

// File: tb/tb_vitis_net_p4.sv
`default_nettype none
// ============================================================================
// Module      : tb_vitis_net_p4
// Description : Self-checking bench for vitis_net_p4: directed cases plus
//               randomized packets with random egress stalls, checked against
//               a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vitis_net_p4;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic         first;
        logic [8:0]   meta;
    } exp_t;

    typedef struct packed {
        logic       first;
        logic       last;
        logic [8:0] meta;
    } log_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [8:0] meta_in;
    logic       meta_in_valid;
    wire  [8:0] meta_out;
    wire        meta_out_valid;

    vitis_net_p4_if #(.TDATA_NUM_BYTES(64)) s_if ();
    vitis_net_p4_if #(.TDATA_NUM_BYTES(64)) m_if ();

    vitis_net_p4 #(
        .TDATA_NUM_BYTES      (64),
        .USER_META_DATA_WIDTH (9)
    ) dut (
        .s_axis_aclk             (clk),
        .s_axis_aresetn          (rst_n),
        .user_metadata_in        (meta_in),
        .user_metadata_in_valid  (meta_in_valid),
        .user_metadata_out       (meta_out),
        .user_metadata_out_valid (meta_out_valid),
        .s_axis                  (s_if),
        .m_axis                  (m_if)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    log_t out_log[$];
    bit   mdl_first = 1'b1;
    logic [8:0] mdl_meta = 9'd0;
    bit   stall_en = 1'b0;
    bit   force_ready = 1'b0;

    task automatic check(input string tag, input logic [599:0] got, input logic [599:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference classification straight from the packet-format rules.
    function automatic logic [8:0] ref_meta(input logic [511:0] d, input logic mv,
                                            input logic [8:0] mi);
        logic [15:0] et;
        logic [7:0]  b14;
        logic [7:0]  b23;
        et  = {d[12*8 +: 8], d[13*8 +: 8]};
        b14 = d[14*8 +: 8];
        b23 = d[23*8 +: 8];
        if (et == 16'h0800 && b14[7:4] == 4'd4) return {1'b1, b23};
        return mv ? mi : 9'd0;
    endfunction

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [63:0] rand_keep();
        return {$urandom, $urandom};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Egress ready: random stalls or a fixed level, changed mid-cycle.
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            m_if.tready = stall_en ? ($urandom_range(0, 3) != 0) : force_ready;
        end
    end

    // Output monitor: stall stability, scoreboard compare and a beat log.
    initial begin : monitor
        logic [599:0] prev_vec;
        logic [599:0] cur_vec;
        bit           prev_stall;
        bit           have_prev;
        exp_t         e;
        have_prev  = 1'b0;
        prev_stall = 1'b0;
        prev_vec   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_prev = 1'b0;
            end else begin
                cur_vec = 600'({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tvalid,
                                meta_out, meta_out_valid});
                if (have_prev && prev_stall) check("stall_hold", cur_vec, prev_vec);
                prev_vec   = cur_vec;
                prev_stall = m_if.tvalid && !m_if.tready;
                have_prev  = 1'b1;
                if (m_if.tvalid && m_if.tready) begin
                    out_log.push_back('{meta_out_valid, m_if.tlast, meta_out});
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_data", m_if.tdata, e.data);
                        check("sb_keep", m_if.tkeep, e.keep);
                        check("sb_last", m_if.tlast, e.last);
                        check("sb_meta_valid", meta_out_valid, e.first);
                        check("sb_meta", meta_out, e.meta);
                    end
                end
            end
        end
    end

    // Present one beat from posedge+1 until accepted; log it in the model.
    task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l,
                             input logic mv, input logic [8:0] mi);
        bit fire;
        int budget;
        s_if.tdata    = d;
        s_if.tkeep    = k;
        s_if.tlast    = l;
        s_if.tvalid   = 1'b1;
        meta_in       = mi;
        meta_in_valid = mv;
        fire   = 1'b0;
        budget = 0;
        while (!fire && budget < 2000) begin
            @(negedge clk);
            fire = s_if.tvalid && s_if.tready;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!fire) begin
            check("send_timeout", 0, 1);
        end else begin
            if (mdl_first) mdl_meta = ref_meta(d, mv, mi);
            exp_q.push_back('{d, k, l, mdl_first, mdl_meta});
            mdl_first = l;
        end
        s_if.tvalid   = 1'b0;
        meta_in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        stall_en    = 1'b0;
        force_ready = 1'b1;
        budget      = 0;
        while (exp_q.size() != 0 && budget < 500) begin
            @(posedge clk);
            #1;
            budget++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [511:0] make_ipv4(input logic [7:0] ver, input logic [7:0] proto);
        logic [511:0] d;
        d = rand_data();
        d[12*8 +: 8] = 8'h08;
        d[13*8 +: 8] = 8'h00;
        d[14*8 +: 8] = ver;
        d[23*8 +: 8] = proto;
        return d;
    endfunction

    function automatic logic [511:0] make_other(input logic [15:0] et);
        logic [511:0] d;
        d = rand_data();
        d[12*8 +: 8] = et[15:8];
        d[13*8 +: 8] = et[7:0];
        return d;
    endfunction

    initial begin : main
        logic [511:0] d;
        logic [63:0]  k;
        int           t0;
        int           len;
        bit           first_exp[4];
        bit           last_exp[4];
        first_exp = '{1'b1, 1'b0, 1'b0, 1'b1};
        last_exp  = '{1'b0, 1'b0, 1'b1, 1'b1};

        s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b0;
        meta_in = '0; meta_in_valid = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", m_if.tvalid, 0);
        check("rst_tlast", m_if.tlast, 0);
        check("rst_tdata", m_if.tdata, 0);
        check("rst_tkeep", m_if.tkeep, 0);
        check("rst_meta", meta_out, 0);
        check("rst_meta_valid", meta_out_valid, 0);
        check("rst_tready", s_if.tready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_tready", s_if.tready, 1);
        @(posedge clk); #1;

        // Non-IPv4 single beat accepted while egress is stalled.
        d = make_other(16'hFD0F);
        k = rand_keep();
        send_beat(d, k, 1'b1, 1'b1, 9'd0);
        @(negedge clk);
        check("t1_tvalid", m_if.tvalid, 1);
        check("t1_tdata", m_if.tdata, d);
        check("t1_tkeep", m_if.tkeep, k);
        check("t1_meta", meta_out, 0);
        check("t1_meta_valid", meta_out_valid, 1);
        repeat (3) @(negedge clk);
        check("t1_hold_tdata", m_if.tdata, d);
        check("t1_hold_meta_valid", meta_out_valid, 1);
        @(posedge clk); #1;
        force_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_cleared", m_if.tvalid, 0);
        @(posedge clk); #1;

        // IPv4 UDP.
        out_log.delete();
        send_beat(make_ipv4(8'h45, 8'h11), rand_keep(), 1'b1, 1'b1, 9'h055);
        drain();
        check("t2_count", out_log.size(), 1);
        check("t2_meta", out_log[0].meta, 9'h111);
        check("t2_meta_valid", out_log[0].first, 1);

        // 3-beat packet back-to-back with a 1-beat IPv4 TCP packet.
        out_log.delete();
        t0 = cyc;
        send_beat(make_other(16'h86DD), rand_keep(), 1'b0, 1'b1, 9'h0A5);
        send_beat(rand_data(), rand_keep(), 1'b0, 1'b1, 9'h1C3);
        send_beat(rand_data(), rand_keep(), 1'b1, 1'b0, 9'h000);
        send_beat(make_ipv4(8'h45, 8'h06), rand_keep(), 1'b1, 1'b1, 9'h033);
        check("t3_no_bubble", cyc - t0, 4);
        drain();
        check("t3_count", out_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t3_meta_valid", out_log[i].first, first_exp[i]);
            check("t3_last", out_log[i].last, last_exp[i]);
        end
        check("t3_meta_pkt1", out_log[0].meta, 9'h0A5);
        check("t3_meta_pkt2", out_log[3].meta, 9'h106);

        // Input metadata not valid on a non-IPv4 first beat.
        out_log.delete();
        send_beat(make_other(16'h1234), rand_keep(), 1'b1, 1'b0, 9'h1FF);
        drain();
        check("t4_meta", out_log[0].meta, 9'h000);
        check("t4_meta_valid", out_log[0].first, 1);

        // Reset in the middle of a packet: next beat starts a new packet.
        send_beat(make_other(16'h0806), rand_keep(), 1'b0, 1'b1, 9'h077);
        send_beat(rand_data(), rand_keep(), 1'b0, 1'b1, 9'h066);
        drain();
        rst_n = 1'b0;
        exp_q.delete();
        mdl_first = 1'b1;
        mdl_meta  = 9'd0;
        @(negedge clk);
        check("t5_rst_tready", s_if.tready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_log.delete();
        send_beat(make_ipv4(8'h45, 8'h2A), rand_keep(), 1'b1, 1'b1, 9'h011);
        drain();
        check("t5_meta_valid", out_log[0].first, 1);
        check("t5_meta", out_log[0].meta, 9'h12A);

        // Random packets under random egress stalls.
        stall_en = 1'b1;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                if (b == 0) begin
                    case ($urandom_range(0, 3))
                        0: d = make_ipv4({4'h4, 4'($urandom)}, 8'($urandom));
                        1: d = make_ipv4(8'($urandom), 8'($urandom));
                        default: d = make_other(16'($urandom));
                    endcase
                end else begin
                    d = rand_data();
                end
                if ($urandom_range(0, 4) == 0) begin
                    @(posedge clk); #1;
                end
                send_beat(d, rand_keep(), (b == len - 1), 1'($urandom), 9'($urandom));
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
